control_unit: RTL and testbench
===============================

# control_unit

Multicycle sequencer for the RISC-V datapath: a four-state Moore FSM that drives every datapath enable and mux select for one load-word instruction per four clock cycles. It reads no instruction fields and implements the fixed sequence fetch → decode/register read → address compute → data-memory read. The write-back of the loaded word overlaps with the following fetch. It sits beside the datapath and exposes its current state on `state_out` for debug and verification.

## Interface
- Parameters: none.
- `clk` input 1: single system clock, rising-edge active.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `PcWrite` output 1: load PC.
- `IMemRead` output 1: instruction-memory read enable.
- `DMemRead` output 1: data-memory read enable.
- `IrWrite` output 1: load instruction register.
- `WriteReg` output 1: register-file write enable.
- `LoadRegA` output 1: load operand register A.
- `LoadRegB` output 1: load operand register B.
- `AluSrcA` output 1: ALU A-input select; 0 = PC, 1 = RegA.
- `AluSrcB` output 2: ALU B-input select; 00 = RegB, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<1.
- `MemToReg` output 1: write-back select; 0 = AluOut, 1 = MDR.
- `LoadAOut` output 1: load ALU-output register.
- `LoadMDR` output 1: load memory data register.
- `PCSrc` output 1: PC source; 0 = live ALU result, 1 = AluOut.
- `SEFct` output 3: immediate format; 000 = I, 001 = S, 010 = SB, 011 = U, 100 = UJ.
- `AluFct` output 3: ALU op; 000 = ADD, 001 = SUB, 010 = AND, 011 = OR, 100 = XOR, 101 = SLT, 110/111 reserved.
- `state_out` output 2: current state encoding.

## Operation
- States: FETCH = 00, DECODE = 01, EXEC = 10, MEM = 11.
- Transitions are unconditional: FETCH→DECODE→EXEC→MEM→FETCH.
- Internal flag `wb_pending`:
  - set on the clock edge leaving MEM;
  - cleared on the clock edge leaving FETCH;
  - cleared by reset.
- Outputs are combinational from the state and `wb_pending` only. Any output not listed for a state is 0.
- FETCH:
  - `IMemRead` = `IrWrite` = `PcWrite` = 1;
  - `AluSrcA` = 0, `AluSrcB` = 01, `AluFct` = 000, `PCSrc` = 0;
  - `WriteReg` = `wb_pending`, `MemToReg` = 1.
- DECODE: `LoadRegA` = `LoadRegB` = 1.
- EXEC: `AluSrcA` = 1, `AluSrcB` = 10, `SEFct` = 000, `AluFct` = 000, `LoadAOut` = 1.
- MEM: `DMemRead` = 1, `LoadMDR` = 1.
- While `reset` = 0, every output is forced to 0 regardless of state, including `state_out` = 00.

## Timing
- Reset assertion takes effect immediately and asynchronously. State becomes FETCH, `wb_pending` becomes 0, and all outputs are 0 while reset is held.
- On reset release, FETCH outputs appear combinationally. The first rising edge with `reset` = 1 moves the FSM to DECODE.
- Latency: exactly 4 cycles per instruction. `state_out` advances by one state on every rising edge.
- The first FETCH after reset has `WriteReg` = 0. Every later FETCH has `WriteReg` = 1, writing the MDR loaded in the previous MEM.
- Reset asserted mid-sequence (for example in EXEC or MEM) abandons the instruction. No write-back is issued after release.
- Releasing reset coincident with a clock edge: the FSM stays in FETCH for that edge and advances on the next one.
- No handshakes and no stall inputs; the FSM never waits.

## Structure
- Shared package `control_pkg` holds:
  - state enum `state_t` (2-bit);
  - `AluSrcB` encodings;
  - `SEFct` encodings;
  - `AluFct` encodings.
- Datapath modules import the same package.
- Single module, no sub-modules. State register and `wb_pending` are in one `always_ff`; output decode is in one `always_comb` with defaults of 0.

## Test plan
- Hold `reset` = 0 for 2 cycles → every output 0, `state_out` = 00.
- Release reset and run 8 edges → `state_out` = 00, 01, 10, 11, 00, 01, 10, 11.
- First FETCH → `PcWrite` = `IMemRead` = `IrWrite` = 1, `AluSrcA` = 0, `AluSrcB` = 01, `AluFct` = 000, `WriteReg` = 0.
- EXEC, then MEM → EXEC shows `AluSrcA` = 1, `AluSrcB` = 10, `SEFct` = 000, `LoadAOut` = 1. MEM shows `DMemRead` = `LoadMDR` = 1 with all other enables 0.
- Second FETCH → `WriteReg` = 1, `MemToReg` = 1.
- Assert reset mid-EXEC, between edges → outputs go to 0 before the next edge. After release, `state_out` = 00 and `WriteReg` = 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RISC-V control unit and its datapath.
package control_pkg;

   localparam int unsigned STATE_W  = 2;
   localparam int unsigned SRCB_W   = 2;
   localparam int unsigned SEFCT_W  = 3;
   localparam int unsigned ALUFCT_W = 3;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10,
      MEM    = 2'b11
   } state_t;

   localparam logic [SRCB_W-1:0] SRCB_REGB    = 2'b00;
   localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SRCB_W-1:0] SRCB_IMM_SH1 = 2'b11;

   localparam logic [SEFCT_W-1:0] SE_I  = 3'b000;
   localparam logic [SEFCT_W-1:0] SE_S  = 3'b001;
   localparam logic [SEFCT_W-1:0] SE_SB = 3'b010;
   localparam logic [SEFCT_W-1:0] SE_U  = 3'b011;
   localparam logic [SEFCT_W-1:0] SE_UJ = 3'b100;

   localparam logic [ALUFCT_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUFCT_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUFCT_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUFCT_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUFCT_W-1:0] ALU_XOR = 3'b100;
   localparam logic [ALUFCT_W-1:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/control_unit.sv
// Four-state Moore sequencer driving the datapath for one load-word per four cycles;
// write-back of the loaded word overlaps the following fetch.
module control_unit
   import control_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   output logic                PcWrite,
   output logic                IMemRead,
   output logic                DMemRead,
   output logic                IrWrite,
   output logic                WriteReg,
   output logic                LoadRegA,
   output logic                LoadRegB,
   output logic                AluSrcA,
   output logic [SRCB_W-1:0]   AluSrcB,
   output logic                MemToReg,
   output logic                LoadAOut,
   output logic                LoadMDR,
   output logic                PCSrc,
   output logic [SEFCT_W-1:0]  SEFct,
   output logic [ALUFCT_W-1:0] AluFct,
   output logic [STATE_W-1:0]  state_out
);

   state_t state_q, state_d;
   logic   wb_pending_q, wb_pending_d;

   // Unconditional ring; wb_pending marks an MDR word awaiting write-back in FETCH.
   always_comb begin
      state_d      = FETCH;
      wb_pending_d = wb_pending_q;
      unique case (state_q)
         FETCH: begin
            state_d      = DECODE;
            wb_pending_d = 1'b0;
         end
         DECODE: state_d = EXEC;
         EXEC:   state_d = MEM;
         MEM: begin
            state_d      = FETCH;
            wb_pending_d = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FETCH;
         wb_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wb_pending_q <= wb_pending_d;
      end
   end

   // Moore decode; everything is held at zero while reset is asserted.
   always_comb begin
      PcWrite   = 1'b0;
      IMemRead  = 1'b0;
      DMemRead  = 1'b0;
      IrWrite   = 1'b0;
      WriteReg  = 1'b0;
      LoadRegA  = 1'b0;
      LoadRegB  = 1'b0;
      AluSrcA   = 1'b0;
      AluSrcB   = SRCB_REGB;
      MemToReg  = 1'b0;
      LoadAOut  = 1'b0;
      LoadMDR   = 1'b0;
      PCSrc     = 1'b0;
      SEFct     = SE_I;
      AluFct    = ALU_ADD;
      state_out = '0;
      if (reset) begin
         state_out = state_q;
         unique case (state_q)
            FETCH: begin
               IMemRead = 1'b1;
               IrWrite  = 1'b1;
               PcWrite  = 1'b1;
               AluSrcA  = 1'b0;
               AluSrcB  = SRCB_FOUR;
               AluFct   = ALU_ADD;
               PCSrc    = 1'b0;
               WriteReg = wb_pending_q;
               MemToReg = 1'b1;
            end
            DECODE: begin
               LoadRegA = 1'b1;
               LoadRegB = 1'b1;
            end
            EXEC: begin
               AluSrcA  = 1'b1;
               AluSrcB  = SRCB_IMM;
               SEFct    = SE_I;
               AluFct   = ALU_ADD;
               LoadAOut = 1'b1;
            end
            MEM: begin
               DMemRead = 1'b1;
               LoadMDR  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed vector bench for control_unit: table-driven sequence plus mid-instruction reset cases.
module tb_control_unit;

   typedef struct packed {
      logic       pc_write;
      logic       imem_read;
      logic       dmem_read;
      logic       ir_write;
      logic       write_reg;
      logic       load_a;
      logic       load_b;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_to_reg;
      logic       load_aout;
      logic       load_mdr;
      logic       pc_src;
      logic [2:0] se_fct;
      logic [2:0] alu_fct;
      logic [1:0] state;
   } out_t;

   typedef struct {
      logic  rst_n;
      out_t  exp;
      string name;
   } vec_t;

   localparam out_t O_ZERO   = '0;
   localparam out_t O_FETCH0 = '{pc_write:1'b1, imem_read:1'b1, ir_write:1'b1,
                                 alu_src_b:2'b01, mem_to_reg:1'b1, default:'0};
   localparam out_t O_FETCH1 = '{pc_write:1'b1, imem_read:1'b1, ir_write:1'b1,
                                 write_reg:1'b1, alu_src_b:2'b01, mem_to_reg:1'b1,
                                 default:'0};
   localparam out_t O_DECODE = '{load_a:1'b1, load_b:1'b1, state:2'b01, default:'0};
   localparam out_t O_EXEC   = '{alu_src_a:1'b1, alu_src_b:2'b10, load_aout:1'b1,
                                 state:2'b10, default:'0};
   localparam out_t O_MEM    = '{dmem_read:1'b1, load_mdr:1'b1, state:2'b11, default:'0};

   logic       clk = 1'b0;
   logic       reset;
   logic       PcWrite, IMemRead, DMemRead, IrWrite, WriteReg, LoadRegA, LoadRegB;
   logic       AluSrcA, MemToReg, LoadAOut, LoadMDR, PCSrc;
   logic [1:0] AluSrcB, state_out;
   logic [2:0] SEFct, AluFct;
   out_t       got;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   control_unit dut (
      .clk      (clk),
      .reset    (reset),
      .PcWrite  (PcWrite),
      .IMemRead (IMemRead),
      .DMemRead (DMemRead),
      .IrWrite  (IrWrite),
      .WriteReg (WriteReg),
      .LoadRegA (LoadRegA),
      .LoadRegB (LoadRegB),
      .AluSrcA  (AluSrcA),
      .AluSrcB  (AluSrcB),
      .MemToReg (MemToReg),
      .LoadAOut (LoadAOut),
      .LoadMDR  (LoadMDR),
      .PCSrc    (PCSrc),
      .SEFct    (SEFct),
      .AluFct   (AluFct),
      .state_out(state_out)
   );

   assign got = '{pc_write:PcWrite, imem_read:IMemRead, dmem_read:DMemRead,
                  ir_write:IrWrite, write_reg:WriteReg, load_a:LoadRegA,
                  load_b:LoadRegB, alu_src_a:AluSrcA, alu_src_b:AluSrcB,
                  mem_to_reg:MemToReg, load_aout:LoadAOut, load_mdr:LoadMDR,
                  pc_src:PCSrc, se_fct:SEFct, alu_fct:AluFct, state:state_out};

   task automatic check(input string name, input out_t exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h (state %b) expected %h (state %b)",
                  name, got, got.state, exp, exp.state);
      end
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b0, O_ZERO,   "reset_hold0"};
      vecs[1]  = '{1'b0, O_ZERO,   "reset_hold1"};
      vecs[2]  = '{1'b1, O_FETCH0, "fetch_first"};
      vecs[3]  = '{1'b1, O_DECODE, "decode1"};
      vecs[4]  = '{1'b1, O_EXEC,   "exec1"};
      vecs[5]  = '{1'b1, O_MEM,    "mem1"};
      vecs[6]  = '{1'b1, O_FETCH1, "fetch_wb2"};
      vecs[7]  = '{1'b1, O_DECODE, "decode2"};
      vecs[8]  = '{1'b1, O_EXEC,   "exec2"};
      vecs[9]  = '{1'b1, O_MEM,    "mem2"};
      vecs[10] = '{1'b1, O_FETCH1, "fetch_wb3"};

      reset = 1'b0;
      for (int i = 0; i < 11; i++) begin
         reset = vecs[i].rst_n;
         #1;
         check(vecs[i].name, vecs[i].exp);
         next_edge();
      end

      // Reset asserted between edges while in EXEC abandons the load.
      check("decode3", O_DECODE);
      next_edge();
      check("exec3", O_EXEC);
      #3 reset = 1'b0;
      #1 check("exec_reset_async", O_ZERO);
      next_edge();
      check("reset_held_edge", O_ZERO);
      reset = 1'b1;
      #1 check("fetch_after_exec_rst", O_FETCH0);
      next_edge();
      check("decode_after_rst", O_DECODE);
      next_edge();
      next_edge();
      check("mem_after_rst", O_MEM);
      next_edge();
      check("fetch_wb_after_rst", O_FETCH1);

      // Reset in MEM must also discard the pending write-back.
      next_edge();
      next_edge();
      next_edge();
      check("mem4", O_MEM);
      #3 reset = 1'b0;
      #1 check("mem_reset_async", O_ZERO);
      next_edge();
      reset = 1'b1;
      #1 check("fetch_after_mem_rst", O_FETCH0);
      next_edge();
      check("decode_after_mem_rst", O_DECODE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
